// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding, error bit positions and pixel width for the WS2812 receiver.
package ws2812_pkg;
    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
    localparam int ERR_OVR = 0;
    localparam int ERR_BAD = 1;
    localparam int ERR_PART = 2;
    localparam int PIX_W = 24;
endpackage

// File: rtl/ws2812_rx_sync.sv
// ws2812_rx_sync: 2-flop synchronizer with a previous-sample flop for rise/fall pulses.
module ws2812_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);
    logic meta, prev;
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            s    <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            s    <= meta;
            prev <= s;
        end
    end
    assign rise = s & ~prev;
    assign fall = ~s & prev;
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes WS2812 NRZ pulses into MSB-first 24-bit GRB pixels,
// flags the latch gap and keeps sticky overrun/bad-pulse/partial errors.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int BIT_THRESH   = 15,
    parameter int MIN_HIGH     = 4,
    parameter int MAX_HIGH     = 40,
    parameter int RESET_CYCLES = 1250,
    parameter int CW           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [PIX_W-1:0] pixel,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic [15:0]      pixel_index,
    output logic             latch,
    output logic [2:0]       err,
    input  logic             err_clr
);
    logic s, rise, fall;
    state_t state, state_n;
    logic [CW-1:0] hcnt, hcnt_n, lcnt, lcnt_n;
    logic [4:0] bits, bits_n;
    logic [PIX_W-1:0] sh, sh_n, pixel_n;
    logic [15:0] fidx, fidx_n, index_n;
    logic latch_n, valid_n, done, load;
    logic [2:0] err_set;

    ws2812_rx_sync u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (din),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        lcnt_n  = lcnt;
        bits_n  = bits;
        sh_n    = sh;
        fidx_n  = fidx;
        latch_n = 1'b0;
        err_set = '0;
        done    = 1'b0;
        case (state)
            SYNC: begin
                lcnt_n = s ? '0 : lcnt + CW'(1);
                if (!s && lcnt + CW'(1) == CW'(RESET_CYCLES)) begin
                    state_n = IDLE;
                    lcnt_n  = '0;
                end
            end
            IDLE: if (rise) begin
                state_n = HIGH;
                hcnt_n  = CW'(1);
            end
            HIGH: begin
                // An over-long pulse means we lost framing; resynchronise on a full gap.
                if (hcnt > CW'(MAX_HIGH)) begin
                    err_set[ERR_BAD] = 1'b1;
                    bits_n  = '0;
                    lcnt_n  = '0;
                    state_n = SYNC;
                end else if (fall) begin
                    state_n = LOW;
                    lcnt_n  = CW'(1);
                    if (hcnt < CW'(MIN_HIGH)) err_set[ERR_BAD] = 1'b1;
                    else begin
                        sh_n   = {sh[PIX_W-2:0], hcnt >= CW'(BIT_THRESH)};
                        done   = bits == 5'(PIX_W - 1);
                        bits_n = done ? '0 : bits + 5'd1;
                        fidx_n = done ? fidx + 16'd1 : fidx;
                    end
                end else hcnt_n = hcnt + CW'(1);
            end
            LOW: begin
                if (rise) begin
                    state_n = HIGH;
                    hcnt_n  = CW'(1);
                end else if (lcnt + CW'(1) == CW'(RESET_CYCLES)) begin
                    latch_n = 1'b1;
                    err_set[ERR_PART] = bits != '0;
                    bits_n  = '0;
                    fidx_n  = '0;
                    lcnt_n  = '0;
                    state_n = IDLE;
                end else lcnt_n = lcnt + CW'(1);
            end
            default: state_n = SYNC;
        endcase
        err_set[ERR_OVR] = done & pixel_valid & ~pixel_ready;
        load    = done & ~(pixel_valid & ~pixel_ready);
        pixel_n = load ? sh_n : pixel;
        index_n = load ? fidx : pixel_index;
        valid_n = load | (pixel_valid & ~pixel_ready);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SYNC;
            hcnt        <= '0;
            lcnt        <= '0;
            bits        <= '0;
            sh          <= '0;
            fidx        <= '0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            latch       <= 1'b0;
            err         <= '0;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            lcnt        <= lcnt_n;
            bits        <= bits_n;
            sh          <= sh_n;
            fidx        <= fidx_n;
            pixel       <= pixel_n;
            pixel_valid <= valid_n;
            pixel_index <= index_n;
            latch       <= latch_n;
            err         <= (err_clr ? 3'b000 : err) | err_set;
        end
    end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed pulse-train stimulus with a pulse-level decoding model and
// a per-cycle compare process for pixels, indices, valid timing and latch timing.
module tb_ws2812_rx;
    localparam int R = 1250, TH = 15, MINH = 4, MAXH = 40;

    logic clk = 1'b0, reset = 1'b0, din = 1'b0, pixel_ready = 1'b1, err_clr = 1'b0;
    logic [23:0] pixel;
    logic pixel_valid, latch;
    logic [15:0] pixel_index;
    logic [2:0] err;
    int total = 0, bad = 0, cyc = 0;

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .pixel      (pixel),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .pixel_index(pixel_index),
        .latch      (latch),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [23:0] w; logic [15:0] i; int c;} pix_t;
    pix_t pq[$];
    int lq[$];
    bit m_sync, m_active, m_held, front_seen;
    int m_bits, run, last_fall, last_latch, hs_count;
    logic [23:0] m_word, last_pix;
    logic [15:0] m_fidx, last_idx;
    logic [2:0] m_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_sync = 0; m_active = 0; m_held = 0; front_seen = 0;
        m_bits = 0; run = 0; m_word = '0; m_fidx = '0; m_err = '0;
        pq.delete(); lq.delete();
    endtask

    // Pulse-level view: a pulse is judged by its width once its fall is driven.
    task automatic model_pulse(int h);
        if (!m_sync) return;
        m_active = 1;
        if (h > MAXH) begin
            m_err[1] = 1; m_bits = 0; m_sync = 0; m_active = 0;
        end else if (h < MINH) m_err[1] = 1;
        else begin
            m_word = {m_word[22:0], h >= TH};
            m_bits++;
            if (m_bits == 24) begin
                m_bits = 0;
                if (m_held && !pixel_ready) m_err[0] = 1;
                else begin
                    pq.push_back('{m_word, m_fidx, last_fall + 3});
                    m_held = !pixel_ready;
                end
                m_fidx++;
            end
        end
    endtask

    task automatic drive(logic v, int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din = v;
        end
    endtask

    task automatic gap(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din = 0;
            run++;
            if (run == R) begin
                if (!m_sync) m_sync = 1;
                else if (m_active) begin
                    lq.push_back(last_fall + R + 2);
                    if (m_bits != 0) m_err[2] = 1;
                    m_bits = 0; m_fidx = 0; m_active = 0;
                end
            end
        end
    endtask

    task automatic pulse(int h, int l);
        drive(1, h);
        run = 0;
        @(negedge clk);
        din = 0;
        run = 1;
        last_fall = cyc;
        model_pulse(h);
        gap(l - 1);
    endtask

    task automatic send(logic [23:0] w);
        for (int i = 23; i >= 0; i--) if (w[i]) pulse(20, 11); else pulse(10, 21);
    endtask

    // PIO WS2812 timing (T1=2, T2=5, T3=3) at a clock divider of 4.
    task automatic pio_word(logic [31:0] v);
        for (int i = 31; i >= 8; i--) if (v[i]) pulse(28, 12); else pulse(8, 32);
    endtask

    task automatic clear_err();
        @(negedge clk); err_clr = 1; m_err = '0;
        @(negedge clk); err_clr = 0;
        #3 chk("err_clr", err, m_err);
    endtask

    task automatic chk_reset_vals();
        chk("rst_pixel", pixel, 0);
        chk("rst_valid", pixel_valid, 0);
        chk("rst_index", pixel_index, 0);
        chk("rst_latch", latch, 0);
        chk("rst_err", err, 0);
    endtask

    always @(negedge clk) begin
        #3;
        if (reset) begin
            chk("latch", latch, lq.size() > 0 && lq[0] == cyc);
            if (latch) last_latch = cyc;
            if (lq.size() > 0 && lq[0] <= cyc) void'(lq.pop_front());
            if (pixel_valid) begin
                if (pq.size() == 0) chk("valid_without_word", pixel_valid, 0);
                else begin
                    if (!front_seen) begin
                        chk("valid_cycle", cyc, pq[0].c);
                        front_seen = 1;
                    end
                    chk("pixel", pixel, pq[0].w);
                    chk("pixel_index", pixel_index, pq[0].i);
                    if (pixel_ready) begin
                        last_pix = pixel; last_idx = pixel_index; hs_count++;
                        void'(pq.pop_front());
                        front_seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        hs_count = 0; last_latch = 0; last_fall = 0; last_pix = '0; last_idx = '0;
        m_reset();
        repeat (4) @(negedge clk);
        #3 chk_reset_vals();
        @(negedge clk); reset = 1;

        gap(1300);
        send(24'hFF00FF);
        gap(1300);
        #3;
        chk("single_count", hs_count, 1);
        chk("single_pixel", last_pix, 24'hFF00FF);
        chk("single_index", last_idx, 0);
        chk("latch_delay", last_latch - last_fall, R + 2);
        chk("single_err", err, 3'b000);

        pixel_ready = 0;
        send(24'h123456);
        send(24'hABCDEF);
        gap(1300);
        #3;
        chk("bp_err", err, 3'b001);
        chk("bp_model_err", err, m_err);
        chk("bp_pixel", pixel, 24'h123456);
        chk("bp_valid", pixel_valid, 1);
        @(negedge clk); pixel_ready = 1; m_held = 0;
        repeat (3) @(negedge clk);
        #3;
        chk("bp_count", hs_count, 2);
        chk("bp_hs_pixel", last_pix, 24'h123456);
        chk("bp_hs_index", last_idx, 0);
        chk("bp_valid_low", pixel_valid, 0);
        clear_err();

        pulse(2, 30);
        pulse(50, 30);
        send(24'hC3C3C3);
        gap(1300);
        send(24'h5A5A5A);
        gap(1300);
        #3;
        chk("glitch_err", err, 3'b010);
        chk("glitch_model_err", err, m_err);
        chk("glitch_count", hs_count, 3);
        chk("glitch_pixel", last_pix, 24'h5A5A5A);
        chk("glitch_index", last_idx, 0);
        clear_err();

        for (int i = 0; i < 10; i++) pulse(20, 11);
        gap(1300);
        #3;
        chk("partial_err", err, 3'b100);
        chk("partial_model_err", err, m_err);
        send(24'h0F0F0F);
        send(24'h00FFA5);
        gap(1300);
        #3;
        chk("partial_count", hs_count, 5);
        chk("partial_pixel", last_pix, 24'h00FFA5);
        chk("partial_index", last_idx, 1);
        clear_err();

        for (int i = 0; i < 12; i++) pulse(20, 11);
        @(negedge clk); reset = 0; m_reset();
        repeat (3) @(negedge clk);
        #3 chk_reset_vals();
        @(negedge clk); reset = 1;
        send(24'h111111);
        gap(1300);
        #3 chk("rst_no_decode", hs_count, 5);
        send(24'h777777);
        gap(1300);
        #3;
        chk("rst_count", hs_count, 6);
        chk("rst_pixel_after", last_pix, 24'h777777);
        chk("rst_index_after", last_idx, 0);

        pio_word(32'hFF00FF00);
        gap(1300);
        #3;
        chk("pio_count", hs_count, 7);
        chk("pio_pixel", last_pix, 24'hFF00FF);
        chk("pio_err", err, 3'b000);
        chk("pending_pixels", pq.size(), 0);
        chk("pending_latches", lq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812 receiver: samples the NRZ pulse-width line driven by the PIO WS2812 program, decodes each high pulse into a bit, assembles MSB-first 24-bit GRB pixels and flags the inter-frame latch gap. It sits on a GPIO input alongside `pio`. It serves as a loopback checker for PIO LED programs and as a daisy-chain front end.

## Interface
Parameters:
- `BIT_THRESH`, 15: high time in cycles; high count `>= BIT_THRESH` decodes as 1, otherwise 0.
- `MIN_HIGH`, 4: high pulses shorter than this are glitches.
- `MAX_HIGH`, 40: high pulses longer than this are errors.
- `RESET_CYCLES`, 1250: low time that constitutes a latch/reset gap (50 us at 25 MHz).
- `CW`, 16: width of the pulse counters; must hold `RESET_CYCLES`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low reset.
- `din` in 1: raw WS2812 line, asynchronous.
- `pixel` out 24: decoded GRB word; bit 23 is the first bit received.
- `pixel_valid` out 1: `pixel` holds an unconsumed word.
- `pixel_ready` in 1: consumer accepts when `pixel_valid && pixel_ready`.
- `pixel_index` out 16: zero-based position of `pixel` within the current frame.
- `latch` out 1: one-cycle pulse when a reset gap completes.
- `err` out 3: sticky flags. [0] overrun, [1] bad_pulse, [2] partial (latch with 1–23 bits pending).
- `err_clr` in 1: clears `err` bits.

## Operation
- Input path: `din` passes through 2 flops (`s`), then a previous-sample flop for edge detection.
- State machine:
  - **SYNC** (reset state): the low counter runs while `s` is 0 and resets to 0 while `s` is 1. On reaching `RESET_CYCLES` it moves to IDLE. No latch pulse is issued on this entry.
  - **IDLE**: on a rising `s`, go to HIGH with the high counter at 1.
  - **HIGH**: the high counter increments, saturating at `MAX_HIGH+1`.
    - Count exceeds `MAX_HIGH`: set `bad_pulse`, clear the bit count, go to SYNC.
    - Falling `s` with count `< MIN_HIGH`: set `bad_pulse`, discard the pulse, go to LOW.
    - Falling `s` otherwise: shift in bit `(cnt >= BIT_THRESH)` and go to LOW.
  - **LOW**: the low counter increments, saturating at `RESET_CYCLES`.
    - Rising `s`: go to HIGH.
    - Counter reaches `RESET_CYCLES`: pulse `latch`. If the bit count is nonzero, set `partial`. Clear the bit count and pixel index, then go to IDLE.
- Pixel assembly:
  - On the 24th bit, the shift register contents load into `pixel` and `pixel_valid` sets.
  - `pixel_index` takes the frame pixel counter, which then increments and wraps at 0xFFFF.
- Overrun: if a 24th bit completes while `pixel_valid && !pixel_ready`, the new word is dropped, `overrun` sets, and the held `pixel` is unchanged. The pixel counter still increments.
- Handshake in the same cycle as a completion: the held word is consumed and the new word loads, with `pixel_valid` staying 1.
- `err_clr` in the same cycle as an error set: the set wins.

## Timing
- Reset values: `pixel`=0, `pixel_valid`=0, `pixel_index`=0, `latch`=0, `err`=0. State is SYNC, all counters are 0.
- Reset asserted mid-frame discards partial bits and any held pixel. After release, a full `RESET_CYCLES` low period is required before bits are accepted.
- Latency from a raw `din` edge to the state machine's view of it is 3 cycles.
- `pixel_valid` rises on the clock edge that registers the falling edge of the 24th pulse, 3 cycles after the raw fall.
- `latch` asserts for exactly 1 cycle, `RESET_CYCLES` cycles after the synced fall of the last pulse.
- High-pulse measurement equals the synced high duration in cycles. Both edges pass through the same 3-cycle delay, so the skew is 0.
- `pixel_valid` falls on the clock edge after the handshake, unless a new word loads in that same cycle.

## Structure
- `ws2812_pkg` holds:
  - the state enum (SYNC, IDLE, HIGH, LOW);
  - error bit indices `ERR_OVR`=0, `ERR_BAD`=1, `ERR_PART`=2;
  - `PIX_W`=24.
- Sub-module `ws2812_rx_sync`: 2-flop synchronizer plus rise/fall pulse outputs. It is reused by other GPIO-input blocks.
- All counters, the shift register, the output register and the FSM live in `ws2812_rx`.

## Test plan
- **Single pixel**:
  - Stimulus: reset, 1300 cycles low, then 24 bits of 0xFF00FF. A 1 is 20 cycles high and 11 low; a 0 is 10 high and 21 low. `pixel_ready`=1.
  - Response: one `pixel_valid` with `pixel`=0xFF00FF and `pixel_index`=0. `latch` pulses 1250 cycles after the last fall. `err`=0.
- **Two pixels with backpressure**:
  - Stimulus: send 0x123456 then 0xABCDEF with `pixel_ready`=0 throughout.
  - Response: `pixel` stays 0x123456 and `err[0]` sets. After raising ready, one handshake occurs with `pixel_index`=0.
- **Glitch and long pulse**:
  - Stimulus: a 2-cycle high pulse, then a 50-cycle high pulse.
  - Response: `err[1]` sets. No bit is recorded for the glitch. The long pulse forces SYNC, and no pixel is output until a 1250-cycle low followed by a fresh 24 bits.
- **Partial frame**:
  - Stimulus: 10 bits, then 1300 cycles low.
  - Response: `latch` pulses and `err[2]` sets. The next frame's first pixel decodes correctly with `pixel_index`=0.
- **Reset mid-frame and start-up**:
  - Stimulus: assert `reset` after 12 bits. After release, send bits immediately with no gap.
  - Response: nothing decodes until a 1250-cycle low is seen. All outputs are at reset values during reset.
- **PIO loopback**:
  - Stimulus: connect `pio` `gpio_out[0]` to `din` and push 0xFF00FF00.
  - Response: `pixel`=0xFF00FF. The bench sets `BIT_THRESH` to the PIO's divided bit timing.
